// File: rtl/dyn_branch_predictor.sv
// Dynamic branch predictor: 2-bit saturating PHT plus direct-mapped BTB.
// Optional gshare indexing is enabled by defining the macro GSHARE_EN.
module dyn_branch_predictor #(
  parameter int PHT_W   = 6,
  parameter int BTB_W   = 4,
  parameter int GHR_LEN = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  output logic        pre_take_o,
  output logic [31:0] pre_target_o,
  input  logic        fb_valid_i,
  input  logic [31:0] fb_pc_i,
  input  logic        fb_taken_i,
  input  logic [31:0] fb_target_i
);

  localparam int PHT_N = 1 << PHT_W;
  localparam int BTB_N = 1 << BTB_W;
  localparam int TAG_W = 31 - BTB_W;

  logic [1:0]       pht_q [PHT_N];
  logic [BTB_N-1:0] btbValid_q;
  logic [TAG_W-1:0] btbTag_q [BTB_N];
  logic [30:0]      btbTarget_q [BTB_N];

  logic [PHT_W-1:0] rdIdx;
  logic [PHT_W-1:0] fbIdx;
  logic [BTB_W-1:0] rdSlot;
  logic [BTB_W-1:0] fbSlot;
  logic [TAG_W-1:0] rdTag;
  logic [TAG_W-1:0] fbTag;
  logic [1:0]       fbCnt;
  logic [1:0]       phtCnt_d;
  logic             btbHit;
  logic             btbWrite;
  logic             unused_ok;

  assign unused_ok = ^{pc_i[0], fb_pc_i[0], fb_target_i[0]};

`ifdef GSHARE_EN
  logic [GHR_LEN-1:0] ghr_q;
  logic [GHR_LEN-1:0] ghr_d;

  // Both lookup and feedback hash with the pre-shift history value.
  assign rdIdx = pc_i[PHT_W:1] ^ PHT_W'(ghr_q);
  assign fbIdx = fb_pc_i[PHT_W:1] ^ PHT_W'(ghr_q);
  assign ghr_d = GHR_LEN'({ghr_q, fb_taken_i});

  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (fb_valid_i) begin
      ghr_q <= ghr_d;
    end
  end
`else
  assign rdIdx = pc_i[PHT_W:1];
  assign fbIdx = fb_pc_i[PHT_W:1];
`endif

  assign rdSlot   = pc_i[BTB_W:1];
  assign fbSlot   = fb_pc_i[BTB_W:1];
  assign rdTag    = pc_i[31:BTB_W+1];
  assign fbTag    = fb_pc_i[31:BTB_W+1];
  assign btbWrite = fb_valid_i & fb_taken_i;

  always_comb begin
    fbCnt    = pht_q[fbIdx];
    phtCnt_d = fbCnt;
    if (fb_taken_i) begin
      if (fbCnt != 2'b11) phtCnt_d = fbCnt + 2'b01;
    end else begin
      if (fbCnt != 2'b00) phtCnt_d = fbCnt - 2'b01;
    end
  end

  // Prediction reads only registered state, so same-cycle feedback shows up next cycle.
  always_comb begin
    btbHit       = btbValid_q[rdSlot] & (btbTag_q[rdSlot] == rdTag);
    pre_take_o   = 1'b0;
    pre_target_o = 32'h0;
    if (!rst && btbHit) begin
      pre_take_o   = pht_q[rdIdx][1];
      pre_target_o = {btbTarget_q[rdSlot], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
    end else if (fb_valid_i) begin
      pht_q[fbIdx] <= phtCnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btbValid_q <= '0;
    end else if (btbWrite) begin
      btbValid_q[fbSlot] <= 1'b1;
    end
  end

  // Tag/target storage needs no reset; the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (!rst && btbWrite) begin
      btbTag_q[fbSlot]    <= fbTag;
      btbTarget_q[fbSlot] <= fb_target_i[31:1];
    end
  end

endmodule

// File: tb/tb_dyn_branch_predictor.sv
// Self-checking bench for dyn_branch_predictor: directed scenarios plus
// randomized traffic compared against a behavioural model.
module tb_dyn_branch_predictor;

  localparam int PHT_W   = 6;
  localparam int BTB_W   = 4;
  localparam int GHR_LEN = 6;
  localparam int PHT_N   = 1 << PHT_W;
  localparam int BTB_N   = 1 << BTB_W;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        pre_take_o;
  logic [31:0] pre_target_o;
  logic        fb_valid_i;
  logic [31:0] fb_pc_i;
  logic        fb_taken_i;
  logic [31:0] fb_target_i;

  int total = 0;
  int bad   = 0;

  // Model state: counter values as plain ints, BTB slots remember the full
  // PC and target of the last taken branch written there.
  int          mCnt [PHT_N];
  bit          mValid [BTB_N];
  logic [31:0] mPc [BTB_N];
  logic [31:0] mTgt [BTB_N];
  int          mGhr;

  dyn_branch_predictor #(
    .PHT_W(PHT_W), .BTB_W(BTB_W), .GHR_LEN(GHR_LEN)
  ) dut (
    .clk(clk), .rst(rst), .pc_i(pc_i),
    .pre_take_o(pre_take_o), .pre_target_o(pre_target_o),
    .fb_valid_i(fb_valid_i), .fb_pc_i(fb_pc_i),
    .fb_taken_i(fb_taken_i), .fb_target_i(fb_target_i)
  );

  always #5 clk = ~clk;

  function automatic int phtIndex(input logic [31:0] pc);
    int idx;
    idx = int'(pc >> 1) % PHT_N;
`ifdef GSHARE_EN
    idx = idx ^ mGhr;
`endif
    return idx;
  endfunction

  function automatic void modelPredict(input logic [31:0] pc, input logic r,
                                       output logic t, output logic [31:0] tgt);
    int  slot;
    bit  hit;
    slot = int'(pc >> 1) % BTB_N;
    hit  = mValid[slot] && ((mPc[slot] >> (BTB_W + 1)) == (pc >> (BTB_W + 1)));
    t    = 1'b0;
    tgt  = 32'h0;
    if (!r && hit) begin
      t   = (mCnt[phtIndex(pc)] >= 2);
      tgt = mTgt[slot] & 32'hFFFF_FFFE;
    end
  endfunction

  task automatic modelUpdate();
    int idx;
    int slot;
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) mCnt[i] = 1;
      for (int i = 0; i < BTB_N; i++) mValid[i] = 1'b0;
      mGhr = 0;
    end else if (fb_valid_i) begin
      idx = phtIndex(fb_pc_i);
      if (fb_taken_i) begin
        if (mCnt[idx] < 3) mCnt[idx]++;
        slot         = int'(fb_pc_i >> 1) % BTB_N;
        mValid[slot] = 1'b1;
        mPc[slot]    = fb_pc_i;
        mTgt[slot]   = fb_target_i;
      end else if (mCnt[idx] > 0) begin
        mCnt[idx]--;
      end
      mGhr = ((mGhr << 1) | int'(fb_taken_i)) % (1 << GHR_LEN);
    end
  endtask

  task automatic checkOutput(input string tag, input logic expTake, input logic [31:0] expTgt);
    total++;
    assert (pre_take_o === expTake) else begin
      bad++;
      $error("[TB] FAIL %s take: got %0b expected %0b", tag, pre_take_o, expTake);
    end
    total++;
    assert (pre_target_o === expTgt) else begin
      bad++;
      $error("[TB] FAIL %s target: got 0x%08h expected 0x%08h", tag, pre_target_o, expTgt);
    end
  endtask

  // Drives one cycle of inputs, checks the combinational prediction against
  // the model before the edge, then advances the model across the edge.
  task automatic applyStimulus(input logic r, input logic [31:0] pc, input logic fv,
                               input logic [31:0] fpc, input logic ft, input logic [31:0] ftgt);
    logic        expT;
    logic [31:0] expG;
    @(negedge clk);
    rst = r; pc_i = pc; fb_valid_i = fv; fb_pc_i = fpc;
    fb_taken_i = ft; fb_target_i = ftgt;
    #1;
    modelPredict(pc, r, expT, expG);
    checkOutput("model", expT, expG);
  endtask

  task automatic tick();
    @(posedge clk);
    modelUpdate();
  endtask

  task automatic lookup(input logic [31:0] pc);
    applyStimulus(1'b0, pc, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic feedback(input logic [31:0] fpc, input logic ft, input logic [31:0] ftgt);
    applyStimulus(1'b0, 32'h0, 1'b1, fpc, ft, ftgt);
    tick();
  endtask

  function automatic logic [31:0] randPc();
    return (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 31)) << 1)
         | 32'($urandom_range(0, 1));
  endfunction

  initial begin
    logic [31:0] rp;
    mGhr = 0;
    for (int i = 0; i < PHT_N; i++) mCnt[i] = 1;
    for (int i = 0; i < BTB_N; i++) mValid[i] = 1'b0;

    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    checkOutput("in_reset", 1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();

    lookup(32'h100);
    checkOutput("after_reset", 1'b0, 32'h0);
    tick();

`ifndef GSHARE_EN
    feedback(32'h100, 1'b1, 32'h200);
    feedback(32'h100, 1'b1, 32'h200);
    lookup(32'h100);
    checkOutput("trained", 1'b1, 32'h200);
    tick();
    feedback(32'h100, 1'b1, 32'h200);
    feedback(32'h100, 1'b0, 32'h0);
    lookup(32'h100);
    checkOutput("one_nt_from_sat", 1'b1, 32'h200);
    tick();
    feedback(32'h100, 1'b0, 32'h0);
    lookup(32'h100);
    checkOutput("weak_nt", 1'b0, 32'h200);
    tick();

    feedback(32'h100, 1'b1, 32'h200);
    feedback(32'h100 + (32'h1 << (BTB_W + 1)), 1'b1, 32'h300);
    lookup(32'h100);
    checkOutput("alias_miss", 1'b0, 32'h0);
    tick();

    applyStimulus(1'b0, 32'h40, 1'b1, 32'h40, 1'b1, 32'h80);
    checkOutput("same_cycle_old", 1'b0, 32'h0);
    tick();
    lookup(32'h40);
    checkOutput("same_cycle_new", 1'b1, 32'h80);
    tick();

    feedback(32'h100, 1'b1, 32'h200);
    feedback(32'h100, 1'b1, 32'h200);
    lookup(32'h100);
    checkOutput("retrained", 1'b1, 32'h200);
    tick();
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200);
    checkOutput("rst_with_fb", 1'b0, 32'h0);
    tick();
    lookup(32'h100);
    checkOutput("cleared", 1'b0, 32'h0);
    tick();
    feedback(32'h100, 1'b1, 32'h200);
    lookup(32'h100);
    checkOutput("first_fb_after_rst", 1'b1, 32'h200);
    tick();
`else
    // History T,T,NT leaves 0b110; slot 0x80>>1 ^ 6 = 6 is still at weak-NT.
    feedback(32'h80, 1'b1, 32'h400);
    feedback(32'h80, 1'b1, 32'h400);
    feedback(32'h80, 1'b0, 32'h0);
    lookup(32'h80);
    checkOutput("gshare_idx", 1'b0, 32'h400);
    tick();
`endif

    for (int n = 0; n < 600; n++) begin
      rp = randPc();
      applyStimulus($urandom_range(0, 49) == 0, rp, $urandom_range(0, 3) != 0,
                    ($urandom_range(0, 2) == 0) ? rp : randPc(),
                    $urandom_range(0, 2) != 0, $urandom());
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dyn_branch_predictor.md
DYN_BRANCH_PREDICTOR -- requirements
Module: dyn_branch_predictor

Interface
REQ-001 Parameter PHT_W, default 6, log2 of pattern-history-table entries (2-bit counters); legal range 2..10.
REQ-002 Parameter BTB_W, default 4, log2 of branch-target-buffer entries, direct-mapped; legal range 1..8.
REQ-003 Parameter GHR_LEN, default 6, global-history length in bits; legal range 1..PHT_W; used only when GSHARE_EN is defined.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 pc_i  input  32  PC of the fetching instruction; bit 0 ignored.
REQ-007 pre_take_o  output  1  predict taken.
REQ-008 pre_target_o  output  32  predicted target; bit 0 always 0.
REQ-009 fb_valid_i  input  1  feedback strobe from EX; low while EX holds a non-branch or is stalled.
REQ-010 fb_pc_i  input  32  PC of the resolved branch.
REQ-011 fb_taken_i  input  1  resolved direction.
REQ-012 fb_target_i  input  32  resolved target; bit 0 ignored.

Function
REQ-013 PHT: 2^PHT_W 2-bit saturating counters; values 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-014 BTB entry: valid bit, tag = pc[31:BTB_W+1], target[31:1]; index = pc[BTB_W:1].
REQ-015 Prediction is combinational from pc_i and current state; zero-cycle latency.
REQ-016 btb_hit = valid & tag match; pre_take_o = btb_hit & PHT[idx][1].
REQ-017 pre_target_o = {target, 1'b0} on btb_hit, else 32'h0.
REQ-018 On fb_valid_i=1: PHT[fb_idx] increments (taken) or decrements (not taken), saturating at 11 and 00.
REQ-019 On fb_valid_i=1 and fb_taken_i=1: BTB[fb_pc_i[BTB_W:1]] written with valid=1, tag of fb_pc_i, fb_target_i[31:1]; overwrites any aliased entry.
REQ-020 On fb_valid_i=1 and fb_taken_i=0: BTB unchanged.
REQ-021 On fb_valid_i=0: no state changes.
REQ-022 Same-cycle prediction and feedback to the same entry: prediction reflects pre-update state; update visible next cycle.
REQ-023 Table indices never exceed table size; all index arithmetic is modulo 2^PHT_W / 2^BTB_W.

Reset
REQ-024 On rst=1 at a clock edge: all PHT counters become 01, all BTB valid bits 0, GHR all zeros (when present).
REQ-025 While rst=1, pre_take_o=0 and pre_target_o=32'h0 irrespective of pc_i.
REQ-026 rst has priority over fb_valid_i in the same cycle; feedback is discarded.
REQ-027 Reset asserted mid-run clears all learned state in one cycle; the first feedback after deassertion is honoured.

Configuration
REQ-028 Macro GSHARE_EN: when defined, a GHR_LEN-bit global history register exists; PHT index = pc[PHT_W:1] XOR zero-extended GHR; fb_idx = fb_pc_i[PHT_W:1] XOR GHR (pre-shift value).
REQ-029 With GSHARE_EN, on fb_valid_i=1 the GHR shifts left by one, fb_taken_i entering bit 0; the oldest bit is dropped.
REQ-030 Without GSHARE_EN: no GHR; bimodal indexing, idx = pc[PHT_W:1], fb_idx = fb_pc_i[PHT_W:1].

Verification
REQ-031 Reset, then pc_i=0x100 -> pre_take_o=0, pre_target_o=0x0.
REQ-032 Bimodal: two taken feedbacks at fb_pc=0x100, fb_target=0x200 -> pc_i=0x100 gives pre_take_o=1, pre_target_o=0x200; a third taken keeps the counter at 11; two not-taken -> 01, pre_take_o=0, pre_target_o still 0x200.
REQ-033 Alias: taken feedback at 0x100 then at 0x100+(2^(BTB_W+1)) -> pc_i=0x100 misses, pre_target_o=0x0.
REQ-034 Same cycle pc_i=fb_pc_i=0x40, counter 01, fb taken -> pre_take_o=0 that cycle, 1 next cycle.
REQ-035 GSHARE_EN: feedbacks T,T,NT at pc 0x80 -> GHR=0b110; a subsequent lookup at 0x80 indexes (0x80>>1 XOR 6) mod 64.
REQ-036 rst asserted concurrently with fb_valid_i=1 after training -> all state cleared; lookup at the trained PC returns 0/0x0.
